// File: rtl/reg_arbiter_seq.sv
// Two-requester arbiter that sequences operations onto a shared 16-bit register.
// Optional REG_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; outputs quiet
// RUN   | driving the register (RegE=1) for the latched repeat count
// ACK   | one-cycle completion pulse to the owner
module reg_arbiter_seq (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [1:0]  Op0,
  input  logic [1:0]  Op1,
  input  logic [15:0] Data0,
  input  logic [15:0] Data1,
  input  logic [3:0]  Cnt0,
  input  logic [3:0]  Cnt1,
  output logic        RegE,
  output logic [1:0]  RegFunSel,
  output logic [15:0] RegI,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Busy,
  output logic        Owner
);

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  op_q, op_nxt;
  logic [15:0] data_q, data_nxt;
  logic        owner_q, owner_nxt;
  logic        pick1;
  logic [1:0]  win_op;
  logic [3:0]  win_cnt;

  // On a conflict, requester 1 wins only when round robin says it is its turn.
`ifdef REG_ARB_ROUND_ROBIN_EN
  assign pick1 = Req1 & (~Req0 | ~owner_q);
`else
  assign pick1 = Req1 & ~Req0;
`endif

  assign win_op  = pick1 ? Op1 : Op0;
  assign win_cnt = pick1 ? Cnt1 : Cnt0;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_q    <= 2'b00;
      data_q  <= 16'h0000;
      owner_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_q    <= op_nxt;
      data_q  <= data_nxt;
      owner_q <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    data_nxt  = data_q;
    owner_nxt = owner_q;
    RegE      = 1'b0;
    RegFunSel = 2'b00;
    RegI      = 16'h0000;
    Ack0      = 1'b0;
    Ack1      = 1'b0;
    Busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (Req0 | Req1) begin
          owner_nxt = pick1;
          op_nxt    = win_op;
          data_nxt  = pick1 ? Data1 : Data0;
          // Load and clear take one cycle; a repeat count of zero still runs once.
          if (win_op[1] || win_cnt == 4'd0)
            cnt_nxt = 4'd1;
          else
            cnt_nxt = win_cnt;
          state_nxt = RUN;
        end
      end
      RUN: begin
        RegE      = 1'b1;
        RegFunSel = op_q;
        RegI      = data_q;
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: begin
        Ack0      = ~owner_q;
        Ack1      = owner_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Owner = owner_q;

endmodule

// File: tb/tb_reg_arbiter_seq.sv
// Directed bench for reg_arbiter_seq; a behavioural copy of the shared register
// follows RegE/RegFunSel/RegI so wrap-around and repeat counts can be observed.
module tb_reg_arbiter_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req0, Req1;
  logic [1:0]  Op0, Op1;
  logic [15:0] Data0, Data1;
  logic [3:0]  Cnt0, Cnt1;
  logic        RegE;
  logic [1:0]  RegFunSel;
  logic [15:0] RegI;
  logic        Ack0, Ack1, Busy, Owner;

  int total = 0;
  int bad   = 0;

  logic        preset;
  logic [15:0] preset_val;
  logic [15:0] model_reg;

  reg_arbiter_seq dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1),
    .Op0(Op0), .Op1(Op1),
    .Data0(Data0), .Data1(Data1),
    .Cnt0(Cnt0), .Cnt1(Cnt1),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI),
    .Ack0(Ack0), .Ack1(Ack1), .Busy(Busy), .Owner(Owner)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (preset) model_reg <= preset_val;
    else if (RegE) begin
      case (RegFunSel)
        2'b00: model_reg <= model_reg - 16'd1;
        2'b01: model_reg <= model_reg + 16'd1;
        2'b10: model_reg <= RegI;
        default: model_reg <= 16'h0000;
      endcase
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_model(input logic [15:0] v);
    preset_val = v;
    preset = 1'b1;
    tick();
    preset = 1'b0;
  endtask

  // Tick until an Ack appears; count RUN cycles and any RUN cycle with wrong function/data.
  task automatic wait_ack(input logic [1:0] efun, input logic [15:0] edata,
                          output int ne, output int nbad,
                          output logic a0, output logic a1, output logic tmo);
    ne = 0; nbad = 0; a0 = 1'b0; a1 = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (Ack0 | Ack1) begin
        a0 = Ack0; a1 = Ack1; tmo = 1'b0;
        if (RegE !== 1'b0 || RegI !== 16'h0 || RegFunSel !== 2'b00) nbad++;
        break;
      end
      if (RegE === 1'b1) begin
        ne++;
        if (RegFunSel !== efun || RegI !== edata) nbad++;
      end else begin
        nbad++;
      end
    end
  endtask

  int   ne, nbad;
  logic a0, a1, tmo;
  logic exp_own [4];

  initial begin
`ifdef REG_ARB_ROUND_ROBIN_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    Op0 = 2'b00; Op1 = 2'b00; Data0 = 16'h0; Data1 = 16'h0;
    Cnt0 = 4'd0; Cnt1 = 4'd0;
    preset = 1'b0; preset_val = 16'h0;
    tick(); tick();

    check("rst_rege", RegE, 1'b0);
    check("rst_funsel", RegFunSel, 2'b00);
    check("rst_regi", RegI, 16'h0);
    check("rst_acks", {Ack0, Ack1}, 2'b00);
    check("rst_busy", Busy, 1'b0);
    check("rst_owner", Owner, 1'b1);
    Reset = 1'b1;
    load_model(16'h0000);

    // Single load by requester 1: 1 RUN cycle, then Ack1, idle on the third.
    Req1 = 1'b1; Op1 = 2'b10; Data1 = 16'hA5A5;
    tick();
    check("load_rege", RegE, 1'b1);
    check("load_funsel", RegFunSel, 2'b10);
    check("load_regi", RegI, 16'hA5A5);
    check("load_busy", Busy, 1'b1);
    check("load_owner", Owner, 1'b1);
    tick();
    check("load_ack", {Ack0, Ack1}, 2'b01);
    check("load_ack_rege", RegE, 1'b0);
    check("load_ack_regi", RegI, 16'h0);
    Req1 = 1'b0;
    tick();
    check("load_idle_busy", Busy, 1'b0);
    check("load_idle_ack", Ack1, 1'b0);
    check("load_model", model_reg, 16'hA5A5);

    // Increment x3 from FFFE wraps to 0001.
    load_model(16'hFFFE);
    Req0 = 1'b1; Op0 = 2'b01; Cnt0 = 4'd3; Data0 = 16'h0042;
    wait_ack(2'b01, 16'h0042, ne, nbad, a0, a1, tmo);
    check("inc_timeout", tmo, 1'b0);
    check("inc_run_len", ne, 3);
    check("inc_run_vals", nbad, 0);
    check("inc_ack", {a0, a1}, 2'b10);
    check("inc_model", model_reg, 16'h0001);
    Req0 = 1'b0;
    tick();
    check("inc_ack_single", {Ack0, Ack1, Busy}, 3'b000);

    // Decrement with Cnt=0 runs exactly once.
    load_model(16'h0000);
    Req0 = 1'b1; Op0 = 2'b00; Cnt0 = 4'd0; Data0 = 16'h0000;
    wait_ack(2'b00, 16'h0000, ne, nbad, a0, a1, tmo);
    check("dec0_timeout", tmo, 1'b0);
    check("dec0_run_len", ne, 1);
    check("dec0_run_vals", nbad, 0);
    check("dec0_ack", {a0, a1}, 2'b10);
    check("dec0_model", model_reg, 16'hFFFF);
    Req0 = 1'b0;
    tick();

    // Inputs change and Req drops mid-run: operation completes with latched values.
    load_model(16'h0010);
    Req0 = 1'b1; Op0 = 2'b01; Cnt0 = 4'd4; Data0 = 16'h1234;
    tick();
    check("hold_first_rege", RegE, 1'b1);
    check("hold_first_regi", RegI, 16'h1234);
    Req0 = 1'b0; Op0 = 2'b11; Cnt0 = 4'd1; Data0 = 16'hFFFF;
    Req1 = 1'b1; Op1 = 2'b10; Data1 = 16'hBEEF;
    wait_ack(2'b01, 16'h1234, ne, nbad, a0, a1, tmo);
    check("hold_timeout", tmo, 1'b0);
    check("hold_run_len", ne, 3);
    check("hold_run_vals", nbad, 0);
    check("hold_ack", {a0, a1}, 2'b10);
    check("hold_model", model_reg, 16'h0014);
    Req1 = 1'b0;
    tick();
    check("hold_idle", Busy, 1'b0);

    // Reset for two cycles in the middle of a 5-cycle increment.
    load_model(16'h0000);
    Req0 = 1'b1; Op0 = 2'b01; Cnt0 = 4'd5; Data0 = 16'h0007;
    tick();
    tick();
    check("mid_busy", Busy, 1'b1);
    Req0 = 1'b0;
    Reset = 1'b0;
    tick();
    check("mid_rst_out", {RegE, RegFunSel, RegI}, 19'h0);
    check("mid_rst_flags", {Ack0, Ack1, Busy, Owner}, 4'b0001);
    tick();
    check("mid_rst2_flags", {RegE, Ack0, Ack1, Busy, Owner}, 5'b00001);
    Reset = 1'b1;
    tick();
    check("mid_after_flags", {RegE, Ack0, Ack1, Busy}, 4'b0000);
    tick();
    check("mid_after2_ack", {Ack0, Ack1}, 2'b00);
    check("mid_model", model_reg, 16'h0002);

    // Both requesters held high; each drops and re-raises around its Ack.
    Op0 = 2'b10; Data0 = 16'h1111;
    Op1 = 2'b10; Data1 = 16'h2222;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(2'b10, exp_own[k] ? 16'h2222 : 16'h1111, ne, nbad, a0, a1, tmo);
      check("arb_timeout", tmo, 1'b0);
      check("arb_owner", a1, exp_own[k]);
      check("arb_onehot", a0 ^ a1, 1'b1);
      check("arb_run_len", ne, 1);
      check("arb_run_vals", nbad, 0);
      if (a1) Req1 = 1'b0;
      else    Req0 = 1'b0;
      tick();
      check("arb_idle", Busy, 1'b0);
      Req0 = 1'b1; Req1 = 1'b1;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
